// File: rtl/gfx_uart_tx.sv
// Buffered UART transmitter for the graphics serial pin: a small byte FIFO fed by
// the GPU, drained by an 8N1/8N2 serialiser that chains frames back to back.
module gfx_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         IN_DATA,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [FIFO_AW:0]   OUT_FIFO_COUNT,
  output logic               OUT_BUSY,
  output logic               OUT_OVERFLOW,
  output logic               OUT_SERIAL_TX
);

  localparam int Depth = 2 ** FIFO_AW;
  localparam int BaudW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [FIFO_AW:0]   fullCount = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]   countOne  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] ptrOne    = FIFO_AW'(1);
  localparam logic [BaudW-1:0]   lastBaud  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BaudW-1:0]   baudOne   = BaudW'(1);
  localparam logic [2:0]         lastStop  = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState;

  logic [7:0]         fifoMem [Depth];
  logic [FIFO_AW-1:0] headPtr, tailPtr;
  logic [FIFO_AW:0]   count;
  logic               overflow;

  txState             state, stateNext;
  logic [BaudW-1:0]   baudCnt, baudNext;
  logic [2:0]         bitIdx, bitNext;
  logic [7:0]         shiftReg, shiftNext;
  logic               txReg, txNext;

  logic fifoFull, fifoEmpty, push, pop, bitEnd;

  assign fifoFull  = (count == fullCount);
  assign fifoEmpty = (count == '0);
  assign push      = IN_VALID & ~fifoFull;
  assign bitEnd    = (baudCnt == lastBaud);

  assign IN_READY       = ~fifoFull;
  assign OUT_FIFO_COUNT = count;
  assign OUT_BUSY       = (state != IDLE) | ~fifoEmpty;
  assign OUT_OVERFLOW   = overflow;
  assign OUT_SERIAL_TX  = txReg;

  // NOTE: the byte storage carries no reset; the pointers and count define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) fifoMem[tailPtr] <= IN_DATA;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tailPtr <= tailPtr + ptrOne;
      if (pop)  headPtr <= headPtr + ptrOne;
      if (push && !pop)      count <= count + countOne;
      else if (pop && !push) count <= count - countOne;
      if (IN_VALID && fifoFull) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
      txReg    <= txNext;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    baudNext  = baudCnt;
    bitNext   = bitIdx;
    shiftNext = shiftReg;
    txNext    = txReg;
    pop       = 1'b0;

    unique case (state)
      IDLE: begin
        txNext = 1'b1;
        if (!fifoEmpty) begin
          pop       = 1'b1;
          shiftNext = fifoMem[headPtr];
          stateNext = START;
          baudNext  = '0;
          txNext    = 1'b0;
        end
      end

      START: begin
        if (bitEnd) begin
          baudNext  = '0;
          bitNext   = '0;
          stateNext = DATA;
          txNext    = shiftReg[0];
        end else begin
          baudNext = baudCnt + baudOne;
        end
      end

      DATA: begin
        if (bitEnd) begin
          baudNext = '0;
          if (bitIdx == 3'd7) begin
            bitNext   = '0;
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            // The line register is loaded with the next bit as the shifter advances.
            bitNext   = bitIdx + 3'd1;
            shiftNext = {1'b0, shiftReg[7:1]};
            txNext    = shiftReg[1];
          end
        end else begin
          baudNext = baudCnt + baudOne;
        end
      end

      STOP: begin
        if (bitEnd) begin
          baudNext = '0;
          if (bitIdx == lastStop) begin
            bitNext = '0;
            if (!fifoEmpty) begin
              pop       = 1'b1;
              shiftNext = fifoMem[headPtr];
              stateNext = START;
              txNext    = 1'b0;
            end else begin
              stateNext = IDLE;
              txNext    = 1'b1;
            end
          end else begin
            bitNext = bitIdx + 3'd1;
          end
        end else begin
          baudNext = baudCnt + baudOne;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gfx_uart_tx.sv
// Self-checking bench for gfx_uart_tx: hand-written frame tables, directed corner
// sequences and randomized pushes against a timeline model of the serial line.
module tb_gfx_uart_tx;

  localparam int CPB    = 4;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int FRAME1 = 10 * CPB;
  localparam int FRAME2 = 11 * CPB;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0]  inData, inData2;
  logic        inValid, inValid2;
  logic        inReady, inReady2;
  logic [AW:0] fifoCount, fifoCount2;
  logic        busy, busy2, overflow, overflow2, serialTx, serialTx2;

  gfx_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW), .STOP_BITS(1)) dut (
    .CLK(CLK), .RESET(RESET), .IN_DATA(inData), .IN_VALID(inValid),
    .IN_READY(inReady), .OUT_FIFO_COUNT(fifoCount), .OUT_BUSY(busy),
    .OUT_OVERFLOW(overflow), .OUT_SERIAL_TX(serialTx)
  );

  gfx_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .IN_DATA(inData2), .IN_VALID(inValid2),
    .IN_READY(inReady2), .OUT_FIFO_COUNT(fifoCount2), .OUT_BUSY(busy2),
    .OUT_OVERFLOW(overflow2), .OUT_SERIAL_TX(serialTx2)
  );

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Line model: each accepted byte owns a frame window starting at edge mStart.
  logic [7:0] mData[$];
  int         mStart[$];
  logic       mOvf;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vecT;
  vecT vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp, n);
    end
  endtask

  function automatic int modelCount(input int e);
    int c = 0;
    foreach (mStart[i]) if (mStart[i] > e) c++;
    return c;
  endfunction

  function automatic logic modelInFrame(input int e);
    foreach (mStart[i]) if (e >= mStart[i] && e < mStart[i] + FRAME1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic modelTx(input int e);
    int b;
    foreach (mStart[i]) begin
      if (e >= mStart[i] && e < mStart[i] + FRAME1) begin
        b = (e - mStart[i]) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return mData[i][b-1];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic modelBusy(input int e);
    return (modelCount(e) > 0) || modelInFrame(e);
  endfunction

  // One clock: offer (v,d) at the coming edge, then compare every output to the model.
  task automatic step(input logic v, input logic [7:0] d);
    int   p, s;
    logic rdy;
    p   = n + 1;
    rdy = modelCount(n) < DEPTH;
    check("in_ready", inReady, rdy);
    inValid = v;
    inData  = d;
    if (v && rdy) begin
      s = p + 1;
      if (mStart.size() > 0 && mStart[$] + FRAME1 > s) s = mStart[$] + FRAME1;
      mData.push_back(d);
      mStart.push_back(s);
    end else if (v) begin
      mOvf = 1'b1;
    end
    @(posedge CLK);
    #1;
    n       = p;
    inValid = 1'b0;
    check("serial_tx", serialTx, modelTx(n));
    check("busy", busy, modelBusy(n));
    check("fifo_count", fifoCount, modelCount(n));
    check("overflow", overflow, mOvf);
  endtask

  task automatic drain();
    int guard = 0;
    while (modelBusy(n) && guard < 2000) begin
      step(1'b0, 8'h00);
      guard++;
    end
    check("drain_timeout", guard < 2000, 1'b1);
  endtask

  task automatic applyReset();
    RESET = 1'b0;
    #1;
    check("rst_tx", serialTx, 1'b1);
    check("rst_count", fifoCount, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_ready", inReady, 1'b1);
    check("rst_tx2", serialTx2, 1'b1);
    mData.delete();
    mStart.delete();
    mOvf = 1'b0;
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    int sFirst, sA, endEdge, guard;
    logic [10:0] frame2;

    inValid = 1'b0; inData = 8'h00;
    inValid2 = 1'b0; inData2 = 8'h00;
    mOvf = 1'b0;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h55, 10'b1010101010};
    vecs[4] = '{8'h3C, 10'b1001111000};

    @(posedge CLK);
    #1;
    applyReset();

    // Single frames from idle, checked bit by bit against hand-built frames.
    for (int v = 0; v < 5; v++) begin
      step(1'b1, vecs[v].data);
      for (int k = 0; k < FRAME1; k++) begin
        step(1'b0, 8'h00);
        check($sformatf("vec%0d_tx_bit%0d", v, k / CPB), serialTx, vecs[v].frame[k / CPB]);
        check($sformatf("vec%0d_busy", v), busy, 1'b1);
      end
      step(1'b0, 8'h00);
      check($sformatf("vec%0d_busy_fall", v), busy, 1'b0);
      check($sformatf("vec%0d_idle_tx", v), serialTx, 1'b1);
    end

    // Three back-to-back bytes: contiguous frames, 120 cycles from first start.
    step(1'b1, 8'h00);
    sFirst = n + 1;
    step(1'b1, 8'hFF);
    step(1'b1, 8'h55);
    guard = 0;
    while (busy && guard < 500) begin
      step(1'b0, 8'h00);
      guard++;
    end
    endEdge = n;
    check("burst_len", endEdge - sFirst, 3 * FRAME1);

    // Push and pop on the same edge with one byte queued.
    step(1'b1, 8'h11);
    sA = n + 1;
    step(1'b1, 8'h22);
    check("pushpop_pre_count", fifoCount, 1);
    while (n < sA + FRAME1 - 1) step(1'b0, 8'h00);
    step(1'b1, 8'h33);
    check("pushpop_count", fifoCount, 1);
    drain();

    // Overflow: 18 consecutive pushes, 17 accepted.
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 8'(8'h40 + i));
      if (i == 16) check("ovf_ready_low", inReady, 1'b0);
    end
    check("ovf_sticky", overflow, 1'b1);
    drain();
    check("ovf_held", overflow, 1'b1);

    // Reset in the middle of data bit 3 with bytes still queued.
    step(1'b1, 8'h00);
    sA = n + 1;
    step(1'b1, 8'h12);
    step(1'b1, 8'h34);
    while (n < sA + CPB + 3 * CPB + 1) step(1'b0, 8'h00);
    check("pre_reset_tx", serialTx, 1'b0);
    applyReset();
    step(1'b1, 8'h3C);
    drain();

    // Randomized pushes with varying offered load.
    for (int blk = 0; blk < 8; blk++) begin
      int rate;
      rate = $urandom_range(3, 70);
      for (int c = 0; c < 200; c++)
        step($urandom_range(0, 99) < rate, 8'($urandom));
    end
    drain();

    // Two stop bits on the second instance.
    frame2 = 11'b11100000010;
    check("s2_idle_tx", serialTx2, 1'b1);
    check("s2_idle_busy", busy2, 1'b0);
    inValid2 = 1'b1;
    inData2  = 8'h81;
    @(posedge CLK);
    #1;
    inValid2 = 1'b0;
    check("s2_count", fifoCount2, 1);
    for (int k = 0; k < FRAME2; k++) begin
      @(posedge CLK);
      #1;
      check($sformatf("s2_tx_bit%0d", k / CPB), serialTx2, frame2[k / CPB]);
      check("s2_busy", busy2, 1'b1);
    end
    @(posedge CLK);
    #1;
    check("s2_busy_fall", busy2, 1'b0);
    check("s2_end_tx", serialTx2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
